// File: rtl/encode4x2_hs.sv
// encode4x2_hs: synchronized active-low 4-to-2 priority encoder with valid/ack handshake.
// Define ENCODE_ROUND_ROBIN_EN for rotating priority based on the previous winner.
module encode4x2_hs #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [0:3] D,
  input  logic       ACK,
  output logic       A,
  output logic       B,
  output logic       V,
  output logic       MULTI
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
  state_t state, state_nx;
  logic [4:0] sync [SYNC_STAGES];
  logic [0:3] ds;
  logic       es;
  logic [1:0] code, win;
  logic       multi_r, capture;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '1;
    end else begin
      sync[0] <= {E, D};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  assign es      = sync[SYNC_STAGES-1][4];
  assign ds      = sync[SYNC_STAGES-1][3:0];
  assign capture = (state == IDLE) && !es && (ds != 4'hF);
`ifdef ENCODE_ROUND_ROBIN_EN
  logic [1:0] last, idx;
  // Scan from lowest to highest priority so the nearest-below-last request wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last - 2'(k);
      if (!ds[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= '0;
    else if (capture) last <= win;
`else
  assign win = !ds[3] ? 2'd3 : !ds[2] ? 2'd2 : !ds[1] ? 2'd1 : 2'd0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      code    <= '0;
      multi_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (capture) begin
        code    <= win;
        multi_r <= $countones(~ds) > 1;
      end
    end
  always_comb
    state_nx = (state == IDLE) ? (capture ? HOLD : IDLE) :
               (state == HOLD) ? (ACK ? WAIT_REL : HOLD) :
               (ds[code] || es) ? IDLE : WAIT_REL;
  always_comb begin
    V     = (state == HOLD);
    A     = code[1];
    B     = code[0];
    MULTI = multi_r;
  end
endmodule

// File: doc/encode4x2_hs.md
Name: encode4x2_hs

Overview:
- Sequential 4-to-2 encoder. Inverse of the team's 2-to-4 decoder with active-low enable and active-low outputs.
- Samples four active-low request lines D[0:3] gated by active-low enable E. Resolves priority and registers a 2-bit code {A,B}.
- Presents the code with a valid/acknowledge handshake.
- Sits on the consumer side of any decoded one-hot-low bus and returns that bus to binary form for downstream control logic.

Parameters:
- SYNC_STAGES, 2, depth of the input synchronizer on D and E. Legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E  input  1  active-low enable. 0 = encoder armed.
- D  input  [0:3]  active-low request lines. D[i]=0 means request i.
- ACK  input  1  consumer acknowledge, active-high, sampled on clk.
- A  output  1  code MSB (index bit 1).
- B  output  1  code LSB (index bit 0).
- V  output  1  code valid, active-high.
- MULTI  output  1  more than one request was low at capture.

Behaviour:
- Reset is one clock with asynchronous active-low assert; release is sampled on the next clk edge.
  - Outputs while rst_n=0: A=0, B=0, V=0, MULTI=0.
  - Internal state: FSM=IDLE. Synchronizer flops for D and E preset to 1 (inactive).
- Synchronizer: D and E each pass through SYNC_STAGES flops. Call the results Ds and Es. All decisions use Ds/Es only.
- FSM states: IDLE, HOLD, WAIT_REL.
- IDLE:
  - If Es=0 and any Ds[i]=0: select the winning index w by priority. On the same edge register {A,B}=w, set V=1, set MULTI=(count of low Ds)>1, and go to HOLD.
  - Otherwise stay in IDLE with V=0. A/B/MULTI hold their last values.
  - Fixed priority: D[3] highest, D[0] lowest.
- HOLD:
  - V=1. A, B and MULTI stay frozen.
  - On an edge where ACK=1: V goes to 0 on that edge and the FSM goes to WAIT_REL.
  - Changes on D or E during HOLD are ignored. E going high does not abort the transaction.
- WAIT_REL:
  - V=0. Leave for IDLE on the first edge where Ds[w]=1 or Es=1.
  - This prevents a held request from being re-encoded repeatedly.
- ACK is ignored in IDLE and WAIT_REL. ACK held high continuously completes each transaction one cycle after its V rises.
- Latency: a request stable before edge k gives V=1 after edge k+SYNC_STAGES. Minimum spacing between transactions is 3 cycles plus the synchronizer delay of the release.
- Simultaneous events:
  - A new request arriving in the same cycle as ACK is not captured until the FSM returns to IDLE.
  - If Ds[w] is released and another request is present, the other request is served in the next IDLE cycle.
- Reset mid-transaction: V drops to 0 immediately (asynchronous) and the pending code is lost. After release the FSM starts in IDLE. A still-active request is re-captured after the synchronizer refills.
- All-ones D (no request) with Es=0: no capture, V stays 0.

Optional Feature:
- Macro: ENCODE_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. A 2-bit register last (reset 0) holds the previous winner. Search order is last-1, last-2, last-3, last (mod 4, descending), so the last winner has lowest priority.
  - last is updated on every capture.
  - With last=0 the order is 3,2,1,0, which equals fixed priority.
- Undefined: fixed priority as above, and no last register is synthesized.

Test Plan:
- Reset: rst_n=0 with D=4'b0000, E=0 -> A=B=V=MULTI=0 asynchronously. After release, V=1 with {A,B}=2'b11 and MULTI=1 after 3 edges (SYNC_STAGES=2).
- Single request: E=0, D=4'b1011 (D[1] low) -> {A,B}=2'b01, V=1, MULTI=0. ACK pulse -> V=0 on that edge. D held low -> no second V until D[1] returns to 1.
- Enable gating: E=1, D=4'b0111 (D[0] low) for 10 cycles -> V never rises. Then E=0 -> {A,B}=2'b00, V=1.
- Priority: D=4'b1100 (D[2],D[3] low) -> {A,B}=2'b11, MULTI=1. With ENCODE_ROUND_ROBIN_EN and D held, after ACK and release of D[3] only (keep D[2] low) -> next capture {A,B}=2'b10.
- Round-robin rotation (ENCODE_ROUND_ROBIN_EN): D=4'b0000 held; pulse E high between transactions; ACK each -> winners 3,2,1,0,3 in sequence. Without the macro -> winner 3 every time.
- Mid-operation reset: assert rst_n=0 while in HOLD with V=1 -> V=0 within the same cycle, ACK afterwards has no effect, and the FSM resumes from IDLE.
